spi_master: RTL and testbench

//  SPI Mode 0 (CPOL=0, CPHA=0) master, single chip-select, MSB first.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sclk_gen.sv | 39 +++
 rtl/spi_master.sv | 109 ++++++++++
 tb/tb_spi_master.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM states, bus mode constants and
// a counter-width helper used by the master and its clock generator.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL
    } spi_state_e;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    // Width of a counter holding 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: while run is high, emits one-cycle rise_en/fall_en
// enables alternately, one every CLK_DIV clk cycles, starting with a rise.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic rise_en,
    output logic fall_en
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          phase;
    logic          tick;

    assign tick    = run && (div_cnt == LAST);
    assign rise_en = tick && !phase;
    assign fall_en = tick && phase;

    // Counter and phase restart whenever the FSM leaves the bus idle
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode 0 master: one DATA_WIDTH word per start pulse, MSB first,
// registered sclk/mosi/cs_n and a one-cycle done strobe with rx_data.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    spi_state_e            state;
    logic [DATA_WIDTH-2:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [BW-1:0]         bit_cnt;
    logic                  run;
    logic                  rise_en;
    logic                  fall_en;

    assign run = (state != IDLE);

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .rise_en(rise_en),
        .fall_en(fall_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            sclk    <= SPI_CPOL;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tx_sr   <= tx_data[DATA_WIDTH-2:0];
                        mosi    <= tx_data[DATA_WIDTH-1];
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= LEAD;
                    end
                end
                // The first rise_en closes the setup period and is rise 0
                LEAD: begin
                    if (rise_en) begin
                        sclk  <= 1'b1;
                        rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (rise_en) begin
                        sclk  <= 1'b1;
                        rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
                    end else if (fall_en) begin
                        sclk <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            mosi  <= 1'b0;
                            state <= TRAIL;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            mosi    <= tx_sr[DATA_WIDTH-2];
                            tx_sr   <= tx_sr << 1;
                        end
                    end
                end
                // Next divider tick ends the cs_n hold time
                TRAIL: begin
                    if (rise_en) begin
                        cs_n    <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sr;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: 8-bit/div-2 and 16-bit/div-1 instances,
// loopback, constant miso and a behavioural slave with random words.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] tx8 = '0;
    logic       busy8, done8, sclk8, mosi8, miso8, cs_n8;
    logic [7:0] rx8;

    logic        start16 = 1'b0;
    logic [15:0] tx16 = '0;
    logic        busy16, done16, sclk16, mosi16, miso16, cs_n16;
    logic [15:0] rx16;

    int errors = 0;
    int checks = 0;

    // 0: loopback, 1: miso tied high, 2: behavioural slave
    int         miso_mode = 0;
    logic [7:0] slv_word = '0;
    logic [7:0] slv_sh = '0;
    logic [7:0] slv_rx = '0;

    assign miso8  = (miso_mode == 0) ? mosi8 :
                    (miso_mode == 1) ? 1'b1 : slv_sh[7];
    assign miso16 = mosi16;

    always @(negedge cs_n8) slv_sh = slv_word;
    always @(negedge sclk8) if (!cs_n8) slv_sh = {slv_sh[6:0], 1'b0};
    always @(posedge sclk8) if (!cs_n8) slv_rx = {slv_rx[6:0], mosi8};

    spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .tx_data(tx8),
        .busy(busy8), .done(done8), .rx_data(rx8), .sclk(sclk8),
        .mosi(mosi8), .miso(miso8), .cs_n(cs_n8)
    );

    spi_master #(.DATA_WIDTH(16), .CLK_DIV(1)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .tx_data(tx16),
        .busy(busy16), .done(done16), .rx_data(rx16), .sclk(sclk16),
        .mosi(mosi16), .miso(miso16), .cs_n(cs_n16)
    );

    // Runs one 8-bit frame; optionally pulses start with 0xFF mid-frame.
    // Latency is counted in clk edges after the accepting edge.
    task automatic frame8(input logic [7:0] tx, input int poke_at,
                          output int lat, output int rises,
                          output logic [7:0] mosi_word,
                          output logic mosi_seen, output logic cs_bad);
        logic prev;
        @(posedge clk); #1;
        tx8 = tx;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        rises = 0;
        mosi_word = '0;
        mosi_seen = mosi8;
        cs_bad = cs_n8 || !busy8;
        prev = sclk8;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == poke_at) begin
                tx8 = 8'hFF;
                start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            if (sclk8 && !prev) begin
                rises++;
                mosi_word = {mosi_word[6:0], mosi8};
            end
            prev = sclk8;
            mosi_seen = mosi_seen | mosi8;
            if (done8) break;
            if (cs_n8) cs_bad = 1'b1;
        end
        start8 = 1'b0;
    endtask

    task automatic frame16(input logic [15:0] tx, output int lat);
        @(posedge clk); #1;
        tx16 = tx;
        start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 0;
        while (lat < 200 && !done16) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sclk8 !== 1'b0 || cs_n8 !== 1'b1 || mosi8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_pins: sclk=%b cs_n=%b mosi=%b, need 0 1 0",
                     sclk8, cs_n8, mosi8);
        end
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b, need 0 0", busy8, done8);
        end
        checks++;
        if (rx8 !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx: got %h, need 00", rx8);
        end
        checks++;
        if (cs_n16 !== 1'b1 || busy16 !== 1'b0 || rx16 !== 16'h0) begin
            errors++;
            $display("FAIL reset_w16: cs_n=%b busy=%b rx=%h, need 1 0 0000",
                     cs_n16, busy16, rx16);
        end
        rst = 1'b0;
    endtask

    task automatic test_loopback();
        int lat, rises;
        logic [7:0] mw;
        logic ms, csb;
        miso_mode = 0;
        frame8(8'hA5, -1, lat, rises, mw, ms, csb);
        checks++;
        if (lat !== 34) begin
            errors++;
            $display("FAIL lb_latency: got %0d, need 34", lat);
        end
        checks++;
        if (rx8 !== 8'hA5) begin
            errors++;
            $display("FAIL lb_rx: got %h, need a5", rx8);
        end
        checks++;
        if (rises !== 8 || mw !== 8'hA5) begin
            errors++;
            $display("FAIL lb_bus: rises=%0d mosi=%h, need 8 a5", rises, mw);
        end
        checks++;
        if (csb !== 1'b0 || cs_n8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL lb_cs: early_high=%b cs_n=%b busy=%b, need 0 1 0",
                     csb, cs_n8, busy8);
        end
        @(posedge clk); #1;
        checks++;
        if (done8 !== 1'b0) begin
            errors++;
            $display("FAIL lb_done_width: done=%b one cycle later, need 0", done8);
        end
    endtask

    task automatic test_miso_ones();
        int lat, rises;
        logic [7:0] mw;
        logic ms, csb;
        miso_mode = 1;
        frame8(8'h00, -1, lat, rises, mw, ms, csb);
        checks++;
        if (rx8 !== 8'hFF) begin
            errors++;
            $display("FAIL ones_rx: got %h, need ff", rx8);
        end
        checks++;
        if (ms !== 1'b0) begin
            errors++;
            $display("FAIL ones_mosi: mosi seen high=%b, need 0", ms);
        end
        miso_mode = 0;
    endtask

    task automatic test_busy_ignore();
        int lat, rises, extra;
        logic [7:0] mw;
        logic ms, csb;
        miso_mode = 0;
        frame8(8'h3C, 9, lat, rises, mw, ms, csb);
        checks++;
        if (rx8 !== 8'h3C || lat !== 34) begin
            errors++;
            $display("FAIL busy_rx: got %h lat %0d, need 3c 34", rx8, lat);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done8 || busy8) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_extra: got %0d extra busy/done cycles, need 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int n, rises, dn, lat;
        logic prev;
        logic [7:0] mw;
        logic ms, csb;
        miso_mode = 0;
        @(posedge clk); #1;
        tx8 = 8'hC7;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        rises = 0;
        dn = 0;
        n = 0;
        prev = sclk8;
        while (rises < 4 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (sclk8 && !prev) rises++;
            prev = sclk8;
            if (done8) dn++;
        end
        checks++;
        if (rises !== 4) begin
            errors++;
            $display("FAIL abort_reach: got %0d rises, need 4", rises);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (cs_n8 !== 1'b1 || sclk8 !== 1'b0 || busy8 !== 1'b0 || rx8 !== 8'h00) begin
            errors++;
            $display("FAIL abort_pins: cs_n=%b sclk=%b busy=%b rx=%h, need 1 0 0 00",
                     cs_n8, sclk8, busy8, rx8);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (done8) dn++;
        end
        checks++;
        if (dn !== 0) begin
            errors++;
            $display("FAIL abort_done: got %0d done pulses, need 0", dn);
        end
        frame8(8'h5A, -1, lat, rises, mw, ms, csb);
        checks++;
        if (rx8 !== 8'h5A || lat !== 34) begin
            errors++;
            $display("FAIL abort_next: rx=%h lat=%0d, need 5a 34", rx8, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, high;
        miso_mode = 0;
        @(posedge clk); #1;
        tx8 = 8'h81;
        start8 = 1'b1;
        @(posedge clk); #1;
        tx8 = 8'h7E;
        lat = 0;
        while (lat < 200 && !done8) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (rx8 !== 8'h81 || lat !== 34) begin
            errors++;
            $display("FAIL b2b_first: rx=%h lat=%0d, need 81 34", rx8, lat);
        end
        high = cs_n8 ? 1 : 0;
        while (cs_n8 && high < 10) begin
            @(posedge clk); #1;
            if (cs_n8) high++;
        end
        start8 = 1'b0;
        checks++;
        if (high !== 1) begin
            errors++;
            $display("FAIL b2b_gap: cs_n high %0d cycles, need 1", high);
        end
        lat = 0;
        while (lat < 200 && !done8) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (rx8 !== 8'h7E || lat !== 34) begin
            errors++;
            $display("FAIL b2b_second: rx=%h lat=%0d, need 7e 34", rx8, lat);
        end
    endtask

    task automatic test_random_slave();
        int lat, rises;
        logic [7:0] mw, tx, sw;
        logic ms, csb;
        miso_mode = 2;
        for (int i = 0; i < 8; i++) begin
            tx = 8'($urandom);
            sw = (i == 0) ? 8'hC3 : 8'($urandom);
            slv_word = sw;
            slv_rx = '0;
            frame8(tx, -1, lat, rises, mw, ms, csb);
            checks++;
            if (rx8 !== sw || slv_rx !== tx || lat !== 34) begin
                errors++;
                $display("FAIL slave_%0d: rx=%h slv_rx=%h lat=%0d, need %h %h 34",
                         i, rx8, slv_rx, lat, sw, tx);
            end
        end
        miso_mode = 0;
    endtask

    task automatic test_width16();
        int lat;
        logic [15:0] tx;
        for (int i = 0; i < 4; i++) begin
            tx = (i == 0) ? 16'h1234 : 16'($urandom);
            frame16(tx, lat);
            checks++;
            if (rx16 !== tx || lat !== 33) begin
                errors++;
                $display("FAIL w16_%0d: rx=%h lat=%0d, need %h 33", i, rx16, lat, tx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_miso_ones();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random_slave();
        test_width16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
